periph_responder: RTL

PERIPH_RESPONDER -- requirements
Module: periph_responder

---
 rtl/periph_responder_pkg.sv | 30 +++
 rtl/periph_timer.sv | 86 ++++++++
 rtl/periph_responder.sv | 108 ++++++++++
 3 files changed

// File: rtl/periph_responder_pkg.sv
// Shared definitions for the CPU data-port responder: peripheral address map,
// timer control bit positions and the value returned for unmapped loads.
package periph_responder_pkg;

    localparam logic [31:0] PERIPH_BASE    = 32'h4000_0000;

    localparam logic [31:0] OFF_TH         = 32'h0000_0000;
    localparam logic [31:0] OFF_TL         = 32'h0000_0004;
    localparam logic [31:0] OFF_TCON       = 32'h0000_0008;
    localparam logic [31:0] OFF_LED        = 32'h0000_000C;
    localparam logic [31:0] OFF_DIGI       = 32'h0000_0010;
    localparam logic [31:0] OFF_SYSTICK    = 32'h0000_0014;

    localparam int          TCON_EN        = 0;
    localparam int          TCON_IE        = 1;
    localparam int          TCON_IS        = 2;

    localparam logic [31:0] UNMAPPED_RDATA = 32'h0000_0000;

    typedef enum logic {
        TMR_IDLE = 1'b0,
        TMR_RUN  = 1'b1
    } tmr_state_e;

    // True when a word address (byte address >> 2) selects the register at off.
    function automatic logic reg_hit(input logic [29:0] waddr, input logic [31:0] off);
        return waddr == 30'((PERIPH_BASE + off) >> 2);
    endfunction

endpackage

// File: rtl/periph_timer.sv
// Reloading 32-bit timer: TH holds the reload value, TL counts up while
// enabled, and an overflow latches TCON.irq_status when interrupts are enabled.
module periph_timer
    import periph_responder_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        wr_th_i,
    input  logic        wr_tl_i,
    input  logic        wr_tcon_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] th_o,
    output logic [31:0] tl_o,
    output logic [31:0] tcon_o,
    output logic        irq_o
);

    tmr_state_e  state_q, state_d;
    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic        ie_q, ie_d;
    logic        is_q, is_d;
    logic        irq_q, irq_d;
    logic        ovf;

    // Timer registers, cleared asynchronously so a reset aborts any count.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= TMR_IDLE;
            th_q    <= '0;
            tl_q    <= '0;
            ie_q    <= 1'b0;
            is_q    <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            th_q    <= th_d;
            tl_q    <= tl_d;
            ie_q    <= ie_d;
            is_q    <= is_d;
            irq_q   <= irq_d;
        end
    end

    // Count/reload per state; CPU stores override the count, overflow beats a status clear.
    always_comb begin
        state_d = state_q;
        th_d    = th_q;
        tl_d    = tl_q;
        ie_d    = ie_q;
        is_d    = is_q;
        ovf     = 1'b0;
        irq_d   = ie_q & is_q;

        case (state_q)
            TMR_IDLE: tl_d = tl_q;
            TMR_RUN: begin
                ovf  = (tl_q == 32'hFFFF_FFFF);
                tl_d = ovf ? th_q : tl_q + 32'd1;
            end
        endcase

        if (wr_th_i) th_d = wdata_i;
        if (wr_tl_i) tl_d = wdata_i;
        if (wr_tcon_i) begin
            state_d = wdata_i[TCON_EN] ? TMR_RUN : TMR_IDLE;
            ie_d    = wdata_i[TCON_IE];
            // Software may only clear the status bit, never set it.
            if (!wdata_i[TCON_IS]) is_d = 1'b0;
        end
        if (ovf && ie_q) is_d = 1'b1;
    end

    // Assemble the TCON view; the enable bit is the FSM state itself.
    always_comb begin
        tcon_o          = '0;
        tcon_o[TCON_EN] = (state_q == TMR_RUN);
        tcon_o[TCON_IE] = ie_q;
        tcon_o[TCON_IS] = is_q;
    end

    assign th_o  = th_q;
    assign tl_o  = tl_q;
    assign irq_o = irq_q;

endmodule

// File: rtl/periph_responder.sv
// CPU data-port responder: word RAM, memory-mapped timer, LED and seven-segment
// registers and a free-running SYSTICK counter. Loads are combinational.
module periph_responder
    import periph_responder_pkg::*;
#(
    parameter int RAM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [7:0]  leds,
    output logic [11:0] digi,
    output logic        irq
);

    localparam int AW = $clog2(RAM_WORDS);

    logic [29:0]   waddr;
    logic [AW-1:0] ram_idx;
    logic          in_ram;
    logic          hit_th, hit_tl, hit_tcon, hit_led, hit_digi, hit_systick;
    logic          unused_addr_bits;

    logic [31:0]   ram_q [RAM_WORDS];
    logic [7:0]    led_q, led_d;
    logic [11:0]   digi_q, digi_d;
    logic [31:0]   systick_q, systick_d;
    logic [31:0]   th, tl, tcon;

    // Byte lane bits play no part in decode.
    assign waddr            = addr[31:2];
    assign unused_addr_bits = ^addr[1:0];
    assign ram_idx          = waddr[AW-1:0];
    assign in_ram           = (waddr[29:AW] == '0);

    assign hit_th      = reg_hit(waddr, OFF_TH);
    assign hit_tl      = reg_hit(waddr, OFF_TL);
    assign hit_tcon    = reg_hit(waddr, OFF_TCON);
    assign hit_led     = reg_hit(waddr, OFF_LED);
    assign hit_digi    = reg_hit(waddr, OFF_DIGI);
    assign hit_systick = reg_hit(waddr, OFF_SYSTICK);

    periph_timer u_timer (
        .clk_i     (clk),
        .reset_i   (reset),
        .wr_th_i   (mem_write & hit_th),
        .wr_tl_i   (mem_write & hit_tl),
        .wr_tcon_i (mem_write & hit_tcon),
        .wdata_i   (wdata),
        .th_o      (th),
        .tl_o      (tl),
        .tcon_o    (tcon),
        .irq_o     (irq)
    );

    // Data RAM; every word clears on reset so loads after reset read zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RAM_WORDS; i++) ram_q[i] <= '0;
        end else if (mem_write && in_ram) begin
            ram_q[ram_idx] <= wdata;
        end
    end

    // Next values of the display registers and the free-running tick counter.
    always_comb begin
        led_d     = led_q;
        digi_d    = digi_q;
        systick_d = systick_q + 32'd1;
        if (mem_write && hit_led)  led_d  = wdata[7:0];
        if (mem_write && hit_digi) digi_d = wdata[11:0];
    end

    // Display and tick registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q     <= '0;
            digi_q    <= '0;
            systick_q <= '0;
        end else begin
            led_q     <= led_d;
            digi_q    <= digi_d;
            systick_q <= systick_d;
        end
    end

    // Load mux: pre-edge contents, zero when idle or unmapped.
    always_comb begin
        rdata = UNMAPPED_RDATA;
        if (mem_read) begin
            if (in_ram)           rdata = ram_q[ram_idx];
            else if (hit_th)      rdata = th;
            else if (hit_tl)      rdata = tl;
            else if (hit_tcon)    rdata = tcon;
            else if (hit_led)     rdata = {24'h0, led_q};
            else if (hit_digi)    rdata = {20'h0, digi_q};
            else if (hit_systick) rdata = systick_q;
        end
    end

    assign leds = led_q;
    assign digi = digi_q;

endmodule
